// File: rtl/uart_matrix_pkg.sv
// uart_matrix_pkg: shared states, header byte, default sizes and element packing helper
package uart_matrix_pkg;
`ifdef UART_MATRIX_LOADER_HDR_SYNC_EN
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, HOLD, WAIT_HDR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;
`endif
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int DEF_DIM = 3;
  localparam int DEF_DATA_W = 8;
  function automatic int elem_lsb(input int k, input int w = DEF_DATA_W);
    return k * w;
  endfunction
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: saturating idle counter that flags when TIMEOUT_CYC cycles pass without a clear
module loader_timeout #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);
  logic [15:0] cnt;
  // count while running, hold at the limit, restart on clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run && cnt != TIMEOUT_CYC) cnt <= cnt + 16'd1;
  assign expired = cnt == TIMEOUT_CYC;
endmodule

// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: assembles matrices A and B from UART bytes; header sync via UART_MATRIX_LOADER_HDR_SYNC_EN
module uart_matrix_loader
  import uart_matrix_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_done,
  input  logic                      rx_err,
  output logic [DIM*DIM*DATA_W-1:0] mat_a,
  output logic [DIM*DIM*DATA_W-1:0] mat_b,
  output logic                      mats_valid,
  input  logic                      mats_ready,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      overrun
);
  localparam int N = DIM * DIM;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic loading, start, take, last, abort, expired, clr;
  assign loading = state == LOAD_A || state == LOAD_B;
`ifdef UART_MATRIX_LOADER_HDR_SYNC_EN
  assign start = (state == IDLE || state == WAIT_HDR) && rx_done && rx_data == DATA_W'(HDR_BYTE);
`else
  assign start = state == IDLE && rx_done;
`endif
  assign take = loading && rx_done && !rx_err;
  assign last = idx == LAST;
  assign abort = loading && (rx_err || (expired && !rx_done));
  assign clr = rx_done || state_n != state;

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(loading), .expired(expired)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // next state: errors and timeouts abort, last element advances, handshake releases HOLD
  always_comb begin
    state_n = state;
    case (state)
`ifdef UART_MATRIX_LOADER_HDR_SYNC_EN
      IDLE:     state_n = start ? LOAD_A : WAIT_HDR;
      WAIT_HDR: state_n = start ? LOAD_A : WAIT_HDR;
`else
      IDLE:     state_n = start ? LOAD_A : IDLE;
`endif
      LOAD_A:   state_n = abort ? IDLE : (take && last) ? LOAD_B : LOAD_A;
      LOAD_B:   state_n = abort ? IDLE : (take && last) ? HOLD : LOAD_B;
      HOLD:     state_n = mats_ready ? IDLE : HOLD;
      default:  state_n = IDLE;
    endcase
  end

  // outputs that follow directly from the state
  always_comb begin
    busy = loading;
    mats_valid = state == HOLD;
  end

  // element storage, index and sticky status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      mat_a <= '0;
      mat_b <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        frame_err <= 1'b0;
        overrun <= 1'b0;
`ifdef UART_MATRIX_LOADER_HDR_SYNC_EN
        idx <= '0;
`else
        mat_a[elem_lsb(0, DATA_W) +: DATA_W] <= rx_data;
        idx <= IW'(1);
`endif
      end
      if (abort) begin
        frame_err <= 1'b1;
        idx <= '0;
      end else if (take) begin
        if (state == LOAD_A) mat_a[elem_lsb(int'(idx), DATA_W) +: DATA_W] <= rx_data;
        else mat_b[elem_lsb(int'(idx), DATA_W) +: DATA_W] <= rx_data;
        idx <= last ? '0 : idx + 1'b1;
      end
      if (state == HOLD && rx_done) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_uart_matrix_loader.sv
// tb_uart_matrix_loader: directed checks of loading, abort, timeout, overrun and reset for DIM=2
module tb_uart_matrix_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_done = 1'b0;
  logic rx_err = 1'b0;
  logic mats_ready = 1'b0;
  logic [31:0] mat_a, mat_b;
  logic mats_valid, busy, frame_err, overrun;
  int n_checks = 0;
  int n_fail = 0;

  uart_matrix_loader #(.DIM(2), .DATA_W(8), .TIMEOUT_CYC(16'd100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
    .mat_a(mat_a), .mat_b(mat_b), .mats_valid(mats_valid), .mats_ready(mats_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic hdr();
`ifdef UART_MATRIX_LOADER_HDR_SYNC_EN
    send_byte(8'hA5);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mat_a"}, mat_a, 0);
    check({tag, "_mat_b"}, mat_b, 0);
    check({tag, "_valid"}, mats_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // frame with 20-cycle spacing, then a long hold before the handshake
    hdr();
    for (int i = 1; i <= 7; i++) begin
      send_byte(8'(i));
      repeat (19) @(negedge clk);
    end
    check("s1_busy_mid", busy, 1);
    check("s1_valid_mid", mats_valid, 0);
    send_byte(8'h08);
    check("s1_valid", mats_valid, 1);
    check("s1_busy", busy, 0);
    check("s1_mat_a", mat_a, 32'h04030201);
    check("s1_mat_b", mat_b, 32'h08070605);
    repeat (50) @(negedge clk);
    check("s1_valid_hold", mats_valid, 1);
    check("s1_mat_a_hold", mat_a, 32'h04030201);
    mats_ready = 1'b1;
    @(negedge clk);
    mats_ready = 1'b0;
    check("s1_valid_clr", mats_valid, 0);

    // receive error after three bytes
    hdr();
    send_byte(8'h11);
    check("s2_busy_first", busy, 1);
    send_byte(8'h12);
    send_byte(8'h13);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    check("s2_ferr", frame_err, 1);
    check("s2_busy", busy, 0);
    check("s2_valid", mats_valid, 0);
    check("s2_partial_a", mat_a, 32'h04131211);
    hdr();
    send_byte(8'h21);
    check("s2_ferr_clr", frame_err, 0);
    for (int i = 2; i <= 8; i++) send_byte(8'h20 + 8'(i));
    check("s2_valid_new", mats_valid, 1);
    check("s2_mat_a", mat_a, 32'h24232221);
    check("s2_mat_b", mat_b, 32'h28272625);
    mats_ready = 1'b1;
    @(negedge clk);
    mats_ready = 1'b0;

    // idle timeout after five bytes
    hdr();
    for (int i = 1; i <= 5; i++) send_byte(8'h30 + 8'(i));
    repeat (100) @(negedge clk);
    check("s3_no_abort_yet", frame_err, 0);
    check("s3_busy_yet", busy, 1);
    @(negedge clk);
    check("s3_ferr", frame_err, 1);
    check("s3_busy", busy, 0);
    check("s3_partial_b", mat_b, 32'h28272635);
    // a byte arriving on the expiry cycle keeps the frame alive
    hdr();
    for (int i = 1; i <= 5; i++) send_byte(8'h40 + 8'(i));
    repeat (100) @(negedge clk);
    send_byte(8'h46);
    check("s3_survive_busy", busy, 1);
    check("s3_survive_ferr", frame_err, 0);
    repeat (99) @(negedge clk);
    send_byte(8'h47);
    send_byte(8'h48);
    check("s3_valid", mats_valid, 1);
    check("s3_mat_a", mat_a, 32'h44434241);
    check("s3_mat_b", mat_b, 32'h48474645);

    // overrun while held, then handshake and byte on the same cycle
    send_byte(8'h55);
    check("s4_ovr", overrun, 1);
    check("s4_valid", mats_valid, 1);
    check("s4_mat_a", mat_a, 32'h44434241);
    check("s4_mat_b", mat_b, 32'h48474645);
    mats_ready = 1'b1;
    send_byte(8'h66);
    mats_ready = 1'b0;
    check("s4_hs_valid", mats_valid, 0);
    check("s4_hs_busy", busy, 0);
    check("s4_hs_ovr", overrun, 1);
    check("s4_hs_mat_a", mat_a, 32'h44434241);
    hdr();
    send_byte(8'h71);
    check("s4_ovr_clr", overrun, 0);
    send_byte(8'h72);
    #2 rst_n = 1'b0;
    #1 check_zero("s4_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // error and byte together in LOAD_B
    hdr();
    for (int i = 1; i <= 5; i++) send_byte(8'h80 + 8'(i));
    rx_err = 1'b1;
    send_byte(8'h99);
    rx_err = 1'b0;
    check("s6_ferr", frame_err, 1);
    check("s6_busy", busy, 0);
    check("s6_mat_a", mat_a, 32'h84838281);
    check("s6_mat_b", mat_b, 32'h00000085);
    check("s6_valid", mats_valid, 0);

`ifdef UART_MATRIX_LOADER_HDR_SYNC_EN
    // header sync: stray byte ignored, header starts the frame unstored
    send_byte(8'h11);
    check("s5_stray_busy", busy, 0);
    send_byte(8'hA5);
    check("s5_hdr_busy", busy, 1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("s5_valid", mats_valid, 1);
    check("s5_mat_a", mat_a, 32'h04030201);
    check("s5_mat_b", mat_b, 32'h08070605);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
